// File: rtl/mem_timing_pkg.sv
// Shared types for the single-bank DRAM timing emulator: bank states, decoded
// commands, strobe bundle, default timing and command-priority decode.
package mem_timing_pkg;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    ACTIVATING  = 4'd1,
    BANK_ACTIVE = 4'd2,
    READING     = 4'd3,
    READING_AP  = 4'd4,
    WRITING     = 4'd5,
    WRITING_AP  = 4'd6,
    PRECHARGING = 4'd7,
    REFRESHING  = 4'd8,
    SELF_REF    = 4'd9,
    POWER_DOWN  = 4'd10,
    ACT_PD      = 4'd11,
    DEEP_PD     = 4'd12,
    MODE_REG    = 4'd13
  } state_t;

  typedef enum logic [4:0] {
    CMD_NONE, CMD_DPD, CMD_SRF, CMD_REF, CMD_PRA, CMD_PR, CMD_BST, CMD_ACT,
    CMD_RDA, CMD_RD, CMD_WRA, CMD_WR, CMD_MRW, CMD_MRR, CMD_CFG, CMD_PD,
    CMD_CKEL, CMD_PDX, CMD_CKEH, CMD_DPDX
  } cmd_t;

  typedef struct packed {
    logic dpd;
    logic srf;
    logic refr;
    logic pra;
    logic pr;
    logic bst;
    logic act;
    logic rda;
    logic rd;
    logic wra;
    logic wr;
    logic mrw;
    logic mrr;
    logic cfg;
    logic pd;
    logic ckel;
    logic pdx;
    logic ckeh;
    logic dpdx;
  } cmd_strobes_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_ROWS    = 128;
  localparam int DEF_COLUMNS = 64;
  localparam int DEF_TRCD    = 4;
  localparam int DEF_TRP     = 4;
  localparam int DEF_TRFC    = 12;
  localparam int DEF_BL      = 8;
  localparam int DEF_TMRD    = 2;
  localparam int CNT_W       = 8;

  // Only the single highest-priority strobe is acted on in a given cycle.
  function automatic cmd_t decode_cmd(input cmd_strobes_t s);
    cmd_t c;
    if      (s.dpd)  c = CMD_DPD;
    else if (s.srf)  c = CMD_SRF;
    else if (s.refr) c = CMD_REF;
    else if (s.pra)  c = CMD_PRA;
    else if (s.pr)   c = CMD_PR;
    else if (s.bst)  c = CMD_BST;
    else if (s.act)  c = CMD_ACT;
    else if (s.rda)  c = CMD_RDA;
    else if (s.rd)   c = CMD_RD;
    else if (s.wra)  c = CMD_WRA;
    else if (s.wr)   c = CMD_WR;
    else if (s.mrw)  c = CMD_MRW;
    else if (s.mrr)  c = CMD_MRR;
    else if (s.cfg)  c = CMD_CFG;
    else if (s.pd)   c = CMD_PD;
    else if (s.ckel) c = CMD_CKEL;
    else if (s.pdx)  c = CMD_PDX;
    else if (s.ckeh) c = CMD_CKEH;
    else if (s.dpdx) c = CMD_DPDX;
    else             c = CMD_NONE;
    return c;
  endfunction

  // Burst state a data command leads to; IDLE means "not a burst command".
  function automatic state_t burst_target(input cmd_t c);
    state_t t;
    case (c)
      CMD_RD:  t = READING;
      CMD_RDA: t = READING_AP;
      CMD_WR:  t = WRITING;
      CMD_WRA: t = WRITING_AP;
      default: t = IDLE;
    endcase
    return t;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_load(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Bank storage: rows*columns words of width bits, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module mem_array #(
  parameter int width   = 8,
  parameter int rows    = 128,
  parameter int columns = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(rows)-1:0]    wr_row,
  input  logic [$clog2(columns)-1:0] wr_col,
  input  logic [width-1:0]           wr_data,
  input  logic [$clog2(rows)-1:0]    rd_row,
  input  logic [$clog2(columns)-1:0] rd_col,
  output logic [width-1:0]           rd_data
);

  logic [width-1:0] mem [rows*columns];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_row, wr_col}] <= wr_data;
    end
  end

  assign rd_data = mem[{rd_row, rd_col}];

endmodule

// File: rtl/mem_timing_wrp.sv
// Single-bank LPDDR-style DRAM emulation: command priority decode, bank-state
// FSM with timing counter, open-row tracking and tri-state data bus.
module mem_timing_wrp
  import mem_timing_pkg::*;
#(
  parameter int width   = DEF_WIDTH,
  parameter int rows    = DEF_ROWS,
  parameter int columns = DEF_COLUMNS,
  parameter int tRCD    = DEF_TRCD,
  parameter int tRP     = DEF_TRP,
  parameter int tRFC    = DEF_TRFC,
  parameter int BL      = DEF_BL,
  parameter int tMRD    = DEF_TMRD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt,
  input  logic                       ACT,
  input  logic                       BST,
  input  logic                       CFG,
  input  logic                       CKEH,
  input  logic                       CKEL,
  input  logic                       DPD,
  input  logic                       DPDX,
  input  logic                       MRR,
  input  logic                       MRW,
  input  logic                       PD,
  input  logic                       PDX,
  input  logic                       PR,
  input  logic                       PRA,
  input  logic                       RD,
  input  logic                       RDA,
  input  logic                       REF,
  input  logic                       SRF,
  input  logic                       WR,
  input  logic                       WRA,
  inout  wire logic [width-1:0]      dq,
  input  logic [$clog2(rows)-1:0]    row,
  input  logic [$clog2(columns)-1:0] column,
  input  logic                       wr_req,
  input  logic                       rd_req,
  output logic [3:0]                 state
);

  state_t                    state_q;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [$clog2(rows)-1:0]   open_row;
  logic                      row_load;
  cmd_strobes_t              strobes;
  cmd_t                      cmd;
  state_t                    burst_state;
  logic                      mem_we;
  logic                      rd_drive;
  logic [width-1:0]          rd_data;

  assign strobes = '{dpd: DPD, srf: SRF, refr: REF, pra: PRA, pr: PR, bst: BST,
                     act: ACT, rda: RDA, rd: RD, wra: WRA, wr: WR, mrw: MRW,
                     mrr: MRR, cfg: CFG, pd: PD, ckel: CKEL, pdx: PDX,
                     ckeh: CKEH, dpdx: DPDX};
  assign cmd         = decode_cmd(strobes);
  assign burst_state = burst_target(cmd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      open_row <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      if (row_load) begin
        open_row <= row;
      end
    end
  end

  // Counted states load N-1 on entry and leave on the cycle cnt reaches 0;
  // halt simply skips the whole update so time stands still.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    row_load  = 1'b0;
    if (!halt) begin
      case (state_q)
        IDLE: begin
          case (cmd)
            CMD_ACT: begin
              state_nxt = ACTIVATING;
              cnt_nxt   = cnt_load(tRCD);
              row_load  = 1'b1;
            end
            CMD_REF: begin
              state_nxt = REFRESHING;
              cnt_nxt   = cnt_load(tRFC);
            end
            CMD_SRF:           state_nxt = SELF_REF;
            CMD_PD, CMD_CKEL:  state_nxt = POWER_DOWN;
            CMD_DPD:           state_nxt = DEEP_PD;
            CMD_MRR, CMD_MRW, CMD_CFG: begin
              state_nxt = MODE_REG;
              cnt_nxt   = cnt_load(tMRD);
            end
            CMD_PR, CMD_PRA: begin
              state_nxt = PRECHARGING;
              cnt_nxt   = cnt_load(tRP);
            end
            default: ;
          endcase
        end
        ACTIVATING: begin
          if (cnt_q == '0) state_nxt = BANK_ACTIVE;
          else             cnt_nxt   = cnt_q - CNT_W'(1);
        end
        BANK_ACTIVE: begin
          if (burst_state != IDLE) begin
            state_nxt = burst_state;
            cnt_nxt   = cnt_load(BL);
          end else begin
            case (cmd)
              CMD_PR, CMD_PRA: begin
                state_nxt = PRECHARGING;
                cnt_nxt   = cnt_load(tRP);
              end
              CMD_PD, CMD_CKEL: state_nxt = ACT_PD;
              default: ;
            endcase
          end
        end
        // A data command during a plain burst restarts it, possibly switching
        // direction or adding auto-precharge.
        READING, WRITING: begin
          if (burst_state != IDLE) begin
            state_nxt = burst_state;
            cnt_nxt   = cnt_load(BL);
          end else if (cmd == CMD_BST) begin
            state_nxt = BANK_ACTIVE;
            cnt_nxt   = '0;
          end else if (cnt_q == '0) begin
            state_nxt = BANK_ACTIVE;
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
        READING_AP, WRITING_AP: begin
          if (cnt_q == '0) begin
            state_nxt = PRECHARGING;
            cnt_nxt   = cnt_load(tRP);
          end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
          end
        end
        PRECHARGING, REFRESHING, MODE_REG: begin
          if (cnt_q == '0) state_nxt = IDLE;
          else             cnt_nxt   = cnt_q - CNT_W'(1);
        end
        SELF_REF: begin
          if (cmd == CMD_CKEH) state_nxt = IDLE;
        end
        POWER_DOWN: begin
          if (cmd == CMD_PDX || cmd == CMD_CKEH) state_nxt = IDLE;
        end
        ACT_PD: begin
          if (cmd == CMD_PDX || cmd == CMD_CKEH) state_nxt = BANK_ACTIVE;
        end
        DEEP_PD: begin
          if (cmd == CMD_DPDX) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign mem_we   = !halt && wr_req && (state_q == WRITING || state_q == WRITING_AP);
  assign rd_drive = rd_req && (state_q == READING || state_q == READING_AP);
  assign dq       = rd_drive ? rd_data : {width{1'bz}};
  assign state    = state_q;

  mem_array #(
    .width   (width),
    .rows    (rows),
    .columns (columns)
  ) u_mem_array (
    .clk     (clk),
    .we      (mem_we),
    .wr_row  (open_row),
    .wr_col  (column),
    .wr_data (dq),
    .rd_row  (open_row),
    .rd_col  (column),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_mem_timing_wrp.sv
// Directed-vector bench for mem_timing_wrp: a table of one-cycle stimulus
// records with expected state/dq, plus a hand-written async-reset sequence.
module tb_mem_timing_wrp;
  import mem_timing_pkg::*;

  typedef enum {
    C_NONE, C_ACT, C_BST, C_CFG, C_CKEH, C_CKEL, C_DPD, C_DPDX, C_MRR, C_MRW,
    C_PD, C_PDX, C_PR, C_PRA, C_RD, C_RDA, C_REF, C_SRF, C_WR, C_WRA
  } tb_cmd_t;

  typedef struct {
    tb_cmd_t    cmd;
    tb_cmd_t    cmd2;
    logic       hlt;
    logic       wr;
    logic       rd;
    logic [6:0] row;
    logic [5:0] col;
    logic       drv;
    logic [7:0] data;
    state_t     exp_state;
    logic       chk;
    logic [7:0] exp_dq;
  } vec_t;

  logic clk, rst, halt;
  logic ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA;
  logic RD, RDA, REF, SRF, WR, WRA;
  logic [6:0] row;
  logic [5:0] column;
  logic wr_req, rd_req;
  logic [3:0] state;
  logic tb_drive;
  logic [7:0] tb_dq;
  tri1 [7:0] dq;

  int n_applied = 0;
  int n_miscompares = 0;
  int vec_idx = 0;
  vec_t vecs[$];

  // Undriven bus floats to 8'hFF through the tri1 pull.
  assign dq = tb_drive ? tb_dq : 8'hzz;

  mem_timing_wrp dut (
    .clk(clk), .rst(rst), .halt(halt),
    .ACT(ACT), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL), .DPD(DPD),
    .DPDX(DPDX), .MRR(MRR), .MRW(MRW), .PD(PD), .PDX(PDX), .PR(PR), .PRA(PRA),
    .RD(RD), .RDA(RDA), .REF(REF), .SRF(SRF), .WR(WR), .WRA(WRA),
    .dq(dq), .row(row), .column(column), .wr_req(wr_req), .rd_req(rd_req),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input tb_cmd_t cmd, input state_t exp,
                              input tb_cmd_t cmd2 = C_NONE, input logic hlt = 1'b0);
    vec_t v;
    v.cmd = cmd; v.cmd2 = cmd2; v.hlt = hlt; v.wr = 1'b0; v.rd = 1'b0;
    v.row = '0; v.col = '0; v.drv = 1'b0; v.data = '0;
    v.exp_state = exp; v.chk = 1'b0; v.exp_dq = '0;
    return v;
  endfunction

  function automatic vec_t mk_act(input logic [6:0] r);
    vec_t v = mk(C_ACT, ACTIVATING);
    v.row = r;
    return v;
  endfunction

  function automatic vec_t mk_w(input tb_cmd_t cmd, input state_t exp, input logic hlt,
                                input logic [5:0] col, input logic [7:0] data);
    vec_t v = mk(cmd, exp, C_NONE, hlt);
    v.wr = 1'b1; v.col = col; v.drv = 1'b1; v.data = data;
    return v;
  endfunction

  function automatic vec_t mk_r(input tb_cmd_t cmd, input state_t exp, input logic hlt,
                                input logic rd, input logic [5:0] col, input logic [7:0] edq);
    vec_t v = mk(cmd, exp, C_NONE, hlt);
    v.rd = rd; v.col = col; v.chk = 1'b1; v.exp_dq = edq;
    return v;
  endfunction

  task automatic add(input tb_cmd_t cmd, input state_t exp, input int n = 1);
    for (int i = 0; i < n; i++) vecs.push_back(mk(cmd, exp));
  endtask

  task automatic add_open(input logic [6:0] r);
    vecs.push_back(mk_act(r));
    add(C_NONE, ACTIVATING, 3);
    add(C_NONE, BANK_ACTIVE);
  endtask

  task automatic set_strobe(input tb_cmd_t c);
    case (c)
      C_ACT:  ACT  = 1'b1;  C_BST:  BST  = 1'b1;  C_CFG:  CFG  = 1'b1;
      C_CKEH: CKEH = 1'b1;  C_CKEL: CKEL = 1'b1;  C_DPD:  DPD  = 1'b1;
      C_DPDX: DPDX = 1'b1;  C_MRR:  MRR  = 1'b1;  C_MRW:  MRW  = 1'b1;
      C_PD:   PD   = 1'b1;  C_PDX:  PDX  = 1'b1;  C_PR:   PR   = 1'b1;
      C_PRA:  PRA  = 1'b1;  C_RD:   RD   = 1'b1;  C_RDA:  RDA  = 1'b1;
      C_REF:  REF  = 1'b1;  C_SRF:  SRF  = 1'b1;  C_WR:   WR   = 1'b1;
      C_WRA:  WRA  = 1'b1;
      default: ;
    endcase
  endtask

  task automatic clear_inputs();
    {ACT, BST, CFG, CKEH, CKEL, DPD, DPDX, MRR, MRW, PD, PDX, PR, PRA} = '0;
    {RD, RDA, REF, SRF, WR, WRA} = '0;
    halt = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    row = '0; column = '0; tb_drive = 1'b0; tb_dq = '0;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] got, input logic [7:0] exp);
    n_applied++;
    if (got !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  // One record = one clock: drive inputs, check combinational dq, clock, check state.
  task automatic applyStimulus(input vec_t v);
    clear_inputs();
    set_strobe(v.cmd);
    set_strobe(v.cmd2);
    halt = v.hlt; wr_req = v.wr; rd_req = v.rd;
    row = v.row; column = v.col; tb_drive = v.drv; tb_dq = v.data;
    #1;
    if (v.chk) checkOutput("dq", vec_idx, dq, v.exp_dq);
    @(posedge clk);
    #1;
    checkOutput("state", vec_idx, {4'h0, state}, {4'h0, v.exp_state});
    vec_idx++;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;

    // ACT latency
    add_open(7'd0);
    add(C_PR, PRECHARGING); add(C_NONE, PRECHARGING, 3); add(C_NONE, IDLE);
    // halt freezes ACTIVATING and drops strobes
    vecs.push_back(mk(C_ACT, IDLE, C_NONE, 1'b1));
    add(C_ACT, ACTIVATING);
    vecs.push_back(mk(C_ACT, ACTIVATING, C_NONE, 1'b1));
    vecs.push_back(mk(C_NONE, ACTIVATING, C_NONE, 1'b1));
    vecs.push_back(mk(C_NONE, ACTIVATING, C_NONE, 1'b1));
    add(C_NONE, ACTIVATING, 3); add(C_NONE, BANK_ACTIVE);
    // WR held 12 cycles, then a halted write that must not land
    for (int i = 0; i < 10; i++) vecs.push_back(mk_w(C_WR, WRITING, 1'b0, 6'd1, 8'h01));
    for (int i = 0; i < 2; i++)  vecs.push_back(mk_w(C_WR, WRITING, 1'b0, 6'd2, 8'h5A));
    vecs.push_back(mk_w(C_NONE, WRITING, 1'b1, 6'd1, 8'hEE));
    add(C_NONE, WRITING, 7); add(C_NONE, BANK_ACTIVE);
    // read burst, dq driven only with rd_req in a read state
    vecs.push_back(mk_r(C_RD,   READING, 1'b0, 1'b1, 6'd1, 8'hFF));
    vecs.push_back(mk_r(C_NONE, READING, 1'b0, 1'b1, 6'd1, 8'h01));
    vecs.push_back(mk_r(C_NONE, READING, 1'b0, 1'b1, 6'd2, 8'h5A));
    vecs.push_back(mk_r(C_NONE, READING, 1'b0, 1'b0, 6'd1, 8'hFF));
    vecs.push_back(mk_r(C_NONE, READING, 1'b1, 1'b1, 6'd1, 8'h01));
    add(C_NONE, READING, 4);
    vecs.push_back(mk_r(C_NONE, BANK_ACTIVE, 1'b0, 1'b0, 6'd1, 8'hFF));
    vecs.push_back(mk_r(C_NONE, BANK_ACTIVE, 1'b0, 1'b1, 6'd1, 8'hFF));
    // BST and mid-burst direction switch
    add(C_RD, READING); add(C_NONE, READING); add(C_BST, BANK_ACTIVE);
    add(C_WR, WRITING); add(C_RD, READING); add(C_BST, BANK_ACTIVE);
    add(C_CKEL, ACT_PD); add(C_RD, ACT_PD); add(C_PDX, BANK_ACTIVE);
    // RDA ignores BST, then auto-precharges
    vecs.push_back(mk_r(C_RDA, READING_AP, 1'b0, 1'b1, 6'd1, 8'hFF));
    vecs.push_back(mk_r(C_BST, READING_AP, 1'b0, 1'b1, 6'd1, 8'h01));
    add(C_NONE, READING_AP, 6); add(C_NONE, PRECHARGING, 4); add(C_NONE, IDLE);
    vecs.push_back(mk_r(C_RD, IDLE, 1'b0, 1'b1, 6'd1, 8'hFF));
    // second row via WRA, then confirm rows are kept apart
    add_open(7'd5);
    vecs.push_back(mk_w(C_WRA,  WRITING_AP, 1'b0, 6'd1, 8'hB7));
    vecs.push_back(mk_w(C_NONE, WRITING_AP, 1'b0, 6'd1, 8'hB7));
    add(C_NONE, WRITING_AP, 6); add(C_NONE, PRECHARGING, 4); add(C_NONE, IDLE);
    add_open(7'd0);
    vecs.push_back(mk_r(C_RD,   READING,     1'b0, 1'b1, 6'd1, 8'hFF));
    vecs.push_back(mk_r(C_BST,  BANK_ACTIVE, 1'b0, 1'b1, 6'd1, 8'h01));
    add(C_PRA, PRECHARGING); add(C_NONE, PRECHARGING, 3); add(C_NONE, IDLE);
    add_open(7'd5);
    vecs.push_back(mk_r(C_RD,   READING,     1'b0, 1'b1, 6'd1, 8'hFF));
    vecs.push_back(mk_r(C_BST,  BANK_ACTIVE, 1'b0, 1'b1, 6'd1, 8'hB7));
    add(C_PR, PRECHARGING); add(C_NONE, PRECHARGING, 3); add(C_NONE, IDLE);
    // refresh wins over a simultaneous ACT
    vecs.push_back(mk(C_REF, REFRESHING, C_ACT));
    add(C_NONE, REFRESHING, 11); add(C_NONE, IDLE);
    // low-power round trips and mode registers
    add(C_SRF, SELF_REF); add(C_PDX, SELF_REF); add(C_CKEH, IDLE);
    vecs.push_back(mk(C_DPD, DEEP_PD, C_SRF));
    add(C_CKEH, DEEP_PD); add(C_DPDX, IDLE);
    add(C_PD, POWER_DOWN); add(C_ACT, POWER_DOWN); add(C_PDX, IDLE);
    add(C_CKEL, POWER_DOWN); add(C_CKEH, IDLE);
    add(C_MRW, MODE_REG); add(C_NONE, MODE_REG); add(C_NONE, IDLE);
    add(C_CFG, MODE_REG); add(C_NONE, MODE_REG); add(C_NONE, IDLE);

    #12;
    checkOutput("reset_state", -1, {4'h0, state}, {4'h0, IDLE});
    checkOutput("reset_dq", -1, dq, 8'hFF);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Async reset in the middle of a write burst.
    applyStimulus(mk_act(7'd0));
    for (int i = 0; i < 3; i++) applyStimulus(mk(C_NONE, ACTIVATING));
    applyStimulus(mk(C_NONE, BANK_ACTIVE));
    applyStimulus(mk_w(C_WR, WRITING, 1'b0, 6'd5, 8'h11));
    applyStimulus(mk_w(C_NONE, WRITING, 1'b0, 6'd5, 8'h11));
    tb_dq = 8'h99;
    #3 rst = 1'b0;
    #1;
    checkOutput("async_rst", vec_idx, {4'h0, state}, {4'h0, IDLE});
    @(posedge clk);
    #1;
    checkOutput("rst_hold", vec_idx, {4'h0, state}, {4'h0, IDLE});
    rst = 1'b1;
    clear_inputs();
    applyStimulus(mk_act(7'd0));
    for (int i = 0; i < 3; i++) applyStimulus(mk(C_NONE, ACTIVATING));
    applyStimulus(mk(C_NONE, BANK_ACTIVE));
    applyStimulus(mk_r(C_RD,   READING, 1'b0, 1'b1, 6'd5, 8'hFF));
    applyStimulus(mk_r(C_NONE, READING, 1'b0, 1'b1, 6'd5, 8'h11));

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
